// File: rtl/types_pkg.sv
// Shared types and constants for the load/store path of the core.
//   DATA_WIDTH        : datapath width
//   RAM_ADDRESS_WIDTH : byte-address width of data memory
//   BYTE_SELECT_WIDTH : width of the access-size field (byte_format)
//   MEM_BE_WIDTH      : byte enables per memory word
//   byte_format       : Byte / HalfWord / Word access size
//   lsu_state         : load_store_unit FSM states
//   is_misaligned()   : natural-alignment check for a size/offset pair
package types_pkg;

   localparam int DATA_WIDTH        = 32;
   localparam int RAM_ADDRESS_WIDTH = 18;
   localparam int BYTE_SELECT_WIDTH = 2;
   localparam int MEM_BE_WIDTH      = 4;

   typedef enum logic [BYTE_SELECT_WIDTH-1:0] {
      Byte     = 2'd0,
      HalfWord = 2'd1,
      Word     = 2'd2
   } byte_format;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state;

   // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
   function automatic logic is_misaligned(input logic [BYTE_SELECT_WIDTH-1:0] size,
                                          input logic [1:0] offset);
      logic result;
      result = 1'b0;
      if (size == HalfWord)
         result = offset[0];
      else if (size != Byte)
         result = |offset;
      return result;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction and extension.
// Selects the addressed byte or halfword lane of a memory word and
// sign- or zero-extends it to DATA_WIDTH. Words pass through unchanged.
// Ports:
//   rdata       in  DATA_WIDTH         raw memory word
//   offset      in  2                  byte offset addr[1:0]
//   size        in  BYTE_SELECT_WIDTH  byte_format of the access
//   is_unsigned in  1                  1 = zero-extend, 0 = sign-extend
//   data        out DATA_WIDTH         extended result
module load_extend
   import types_pkg::*;
(
   input  logic [DATA_WIDTH-1:0]        rdata,
   input  logic [1:0]                   offset,
   input  logic [BYTE_SELECT_WIDTH-1:0] size,
   input  logic                         is_unsigned,
   output logic [DATA_WIDTH-1:0]        data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Halfword lane uses only offset[1]: an odd halfword address reads the
   // enclosing aligned halfword.
   assign byte_lane = rdata[{offset, 3'b000} +: 8];
   assign half_lane = rdata[{offset[1], 4'b0000} +: 16];

   always_comb begin
      data = rdata;
      case (size)
         Byte:     data = {{(DATA_WIDTH-8){~is_unsigned & byte_lane[7]}}, byte_lane};
         HalfWord: data = {{(DATA_WIDTH-16){~is_unsigned & half_lane[15]}}, half_lane};
         default:  data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Accepts one request from the execute stage,
// drives a byte-enabled word memory port through a req/gnt/rvalid handshake,
// lane-aligns store data, and returns extended load data with a one-cycle
// resp_valid pulse. stall holds the pipeline while a transaction is in flight.
// Optional feature macro: MISALIGN_TRAP_EN -- misaligned halfword/word
// requests skip memory and complete immediately with misaligned=1.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write/size/unsigned      access type
//   req_addr, req_wdata          byte address, right-justified store data
//   stall                        freeze upstream pipeline
//   resp_valid/rdata/misaligned  completion pulse and result
//   mem_req/we/be/addr/wdata     memory request (word address)
//   mem_gnt/rvalid/rdata         memory grant and read response
module load_store_unit
   import types_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_write,
   input  logic [BYTE_SELECT_WIDTH-1:0]   req_size,
   input  logic                           req_unsigned,
   input  logic [DATA_WIDTH-1:0]          req_addr,
   input  logic [DATA_WIDTH-1:0]          req_wdata,
   output logic                           stall,
   output logic                           resp_valid,
   output logic [DATA_WIDTH-1:0]          resp_rdata,
   output logic                           misaligned,
   output logic                           mem_req,
   output logic                           mem_we,
   output logic [MEM_BE_WIDTH-1:0]        mem_be,
   output logic [RAM_ADDRESS_WIDTH-3:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]          mem_wdata,
   input  logic                           mem_gnt,
   input  logic                           mem_rvalid,
   input  logic [DATA_WIDTH-1:0]          mem_rdata
);

   lsu_state state_reg, state_next;

   logic                         write_reg;
   logic [BYTE_SELECT_WIDTH-1:0] size_reg;
   logic                         unsigned_reg;
   logic [1:0]                   offset_reg;
   logic                         mem_req_reg;
   logic [MEM_BE_WIDTH-1:0]      mem_be_reg;
   logic [RAM_ADDRESS_WIDTH-3:0] mem_addr_reg;
   logic [DATA_WIDTH-1:0]        mem_wdata_reg;
   logic                         resp_valid_reg;
   logic [DATA_WIDTH-1:0]        resp_rdata_reg;
   logic                         misaligned_reg;

   logic                         accept;
   logic                         trap_now;
   logic [MEM_BE_WIDTH-1:0]      be_next;
   logic [DATA_WIDTH-1:0]        wdata_next;
   logic [DATA_WIDTH-1:0]        load_data;
   logic                         unused_addr_bits;

   // Address bits above the data-memory range are architecturally ignored.
   assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:RAM_ADDRESS_WIDTH];

   assign accept = (state_reg == IDLE) && req_valid;

`ifdef MISALIGN_TRAP_EN
   assign trap_now = is_misaligned(req_size, req_addr[1:0]);
`else
   assign trap_now = 1'b0;
`endif

   // Store lane placement: replicate the datum across the word so every
   // enabled lane already carries the right byte.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = req_wdata;
      case (req_size)
         Byte: begin
            be_next    = 4'b0001 << req_addr[1:0];
            wdata_next = {4{req_wdata[7:0]}};
         end
         HalfWord: begin
            be_next    = 4'b0011 << {req_addr[1], 1'b0};
            wdata_next = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   load_extend u_load_extend (
      .rdata       (mem_rdata),
      .offset      (offset_reg),
      .size        (size_reg),
      .is_unsigned (unsigned_reg),
      .data        (load_data)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (req_valid) state_next = trap_now ? RESP : REQ;
         REQ:  if (mem_gnt)   state_next = write_reg ? RESP : WAIT;
         WAIT: if (mem_rvalid) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         write_reg      <= 1'b0;
         size_reg       <= '0;
         unsigned_reg   <= 1'b0;
         offset_reg     <= '0;
         mem_req_reg    <= 1'b0;
         mem_be_reg     <= '0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         resp_valid_reg <= 1'b0;
         resp_rdata_reg <= '0;
         misaligned_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         // Registered from next state so mem_req/resp_valid are glitch-free flops.
         mem_req_reg    <= (state_next == REQ);
         resp_valid_reg <= (state_next == RESP);
         if (accept) begin
            write_reg      <= req_write;
            size_reg       <= req_size;
            unsigned_reg   <= req_unsigned;
            offset_reg     <= req_addr[1:0];
            mem_be_reg     <= be_next;
            mem_addr_reg   <= req_addr[RAM_ADDRESS_WIDTH-1:2];
            mem_wdata_reg  <= wdata_next;
            resp_rdata_reg <= '0;
            misaligned_reg <= trap_now;
         end
         if ((state_reg == WAIT) && mem_rvalid)
            resp_rdata_reg <= load_data;
      end
   end

   assign req_ready  = (state_reg == IDLE);
   assign stall      = accept || (state_reg == REQ) || (state_reg == WAIT);
   assign resp_valid = resp_valid_reg;
   assign resp_rdata = resp_rdata_reg;
   assign misaligned = misaligned_reg;
   assign mem_req    = mem_req_reg;
   assign mem_we     = write_reg;
   assign mem_be     = mem_be_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;

endmodule
